aud_ram_mon_tx: RTL and testbench
=================================

Name: aud_ram_mon_tx

Overview:
- Command sequencer for AUD RAM-monitor mode.
- Accepts one memory read/write command at a time from the host command FIFO using a valid/ready handshake.
- Serialises the command onto the AUD pins (clock, nsync, 4-bit data), then releases the bus and collects the target's ready/busy status and any read data.
- Returns a single response word. Sits between the host-side command FIFO and the AUD pad ring.

Parameters:
g_clk_div, 2, AUD_CK half-period in clk_sys_i cycles (>=1)
g_timeout, 1024, max consecutive busy status samples before the command is aborted with an error

Ports:
clk_sys_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  block can accept a command
cmd_write_i  in  1  1=write, 0=read
cmd_size_i  in  2  00=byte, 01=word, 10=long, 11=reserved
cmd_addr_i  in  32  target address
cmd_data_i  in  32  write data, right-justified
rsp_valid_o  out  1  response available
rsp_ready_i  in  1  response consumed
rsp_data_o  out  32  read data, right-justified, zero-extended; 0 for writes or errors
rsp_err_o  out  1  timeout, protocol error or reserved size
aud_ck_o  out  1  AUD clock to target
aud_nsync_o  out  1  frame sync, active low
aud_data_o  out  4  nibble driven to target
aud_data_oe_o  out  1  pad output enable for aud_data
aud_data_i  in  4  nibble from pad
busy_o  out  1  high whenever state is not IDLE

Behaviour:
- Reset values (next cycle after rst_i=1, from any state):
  - state=IDLE, cmd_ready_o=1, rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0
  - aud_ck_o=1, aud_nsync_o=1, aud_data_o=0, aud_data_oe_o=0, busy_o=0
  - Reset mid-frame abandons the frame with no response.
- Handshake:
  - A command is accepted on a cycle where cmd_valid_i & cmd_ready_o.
  - cmd_ready_o=1 only in IDLE.
  - A response is consumed on a cycle where rsp_valid_o & rsp_ready_i.
  - rsp_* hold stable while rsp_valid_o=1.
- Nibble count N from cmd_size_i: byte=2, word=4, long=8.
- AUD_CK: while busy, low for g_clk_div cycles, then high for g_clk_div cycles; one period carries one nibble. In IDLE/RESP it is held high.
- Outputs change only at the start of the low phase. Input is sampled in the last cycle of the high phase, i.e. the cycle before the next falling edge.
- States and transitions:
  - IDLE:
    - On accept with size=11: go to RESP with rsp_err_o=1, rsp_data_o=0, and no pin activity.
    - On accept with any other size: latch the command; the next cycle is the first falling edge; go to SEND.
  - SEND:
    - aud_nsync_o=0, aud_data_oe_o=1.
    - Nibble sequence: command nibble {cmd_write_i, 1'b0, cmd_size_i}; then addr[31:28] down to addr[3:0]; then, if write, the low N nibbles of data, MSN first.
    - After the last nibble period, go to TURN.
  - TURN:
    - Lasts one AUD_CK period with aud_nsync_o=1, aud_data_oe_o=0 and aud_data_o=0; no sampling.
    - Then go to WAIT.
  - WAIT:
    - Sample once per period.
    - 0000 = busy: increment the busy counter. When the counter reaches g_timeout, go to RESP with rsp_err_o=1.
    - 0001 = ready: clear the counter. Reads go to READ; writes go to RESP with rsp_err_o=0.
    - Any other value: go to RESP with rsp_err_o=1 (protocol error).
  - READ:
    - Sample N nibbles, MSN first, shifting into rsp_data_o from the LSB.
    - Then go to RESP with rsp_err_o=0.
  - RESP:
    - Entered with aud_ck_o=1 and outputs at idle values; rsp_valid_o=1.
    - On consume, return to IDLE. cmd_ready_o rises in that same cycle, not before.
- Error responses: rsp_data_o=0.
- Counters and widths:
  - Phase counter width clog2(g_clk_div)+1.
  - Nibble counter 0..16.
  - Busy counter width clog2(g_timeout+1).
  - No wrap allowed: the busy counter saturates at g_timeout.
- A command arriving while not IDLE is left pending on cmd_valid_i (ready=0). No back-to-back bypass: at least one IDLE cycle lies between responses.

Test Plan:
- Read byte at 0x0000_1234 (g_clk_div=2):
  - Stimulus: target returns 0000 twice, 0001, then 0xA, 0x5.
  - Nibbles out: 0x0,0x0,0x0,0x0,0x0,0x1,0x2,0x3,0x4, each held 4 cycles with nsync low.
  - Response: rsp_data_o=0x0000_00A5, rsp_err_o=0.
- Write long 0xDEADBEEF to 0x8000_0000:
  - Nibbles out: 0x A, 8,0,0,0,0,0,0,0, D,E,A,D,B,E,E,F (17 periods = 68 cycles), then one turnaround period with oe=0.
  - Stimulus: immediate 0001.
  - Response: rsp_valid_o=1, rsp_err_o=0, rsp_data_o=0.
- Timeout (g_timeout=4): target holds 0000 -> rsp_err_o=1 after exactly 4 WAIT samples; rsp_data_o=0.
- Protocol error: WAIT sample 0x7 -> rsp_err_o=1 immediately; no READ phase occurs.
- Reserved size 11 -> aud_ck_o stays 1, oe stays 0; rsp_valid_o=1, rsp_err_o=1 one cycle after accept. Hold rsp_ready_i=0 for 10 cycles -> response stable and cmd_ready_o=0 throughout.
- Reset mid-SEND (rst_i at nibble 3) -> next cycle all pins at idle values and cmd_ready_o=1; no response is issued; a following read word completes normally.

Source files
------------

// File: rtl/aud_ram_mon_tx_if.sv
// ---------------------------------------------------------------------------
// aud_ram_mon_tx_if
// Host-side command/response channel of the AUD RAM-monitor sequencer.
//   cmd_*  : one memory command, valid/ready handshake (host -> sequencer)
//   rsp_*  : one response word, valid/ready handshake (sequencer -> host)
// Modports: master = host side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface aud_ram_mon_tx_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_write_i;
    logic [1:0]  cmd_size_i;
    logic [31:0] cmd_addr_i;
    logic [31:0] cmd_data_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;

    modport master (
        output cmd_valid_i, cmd_write_i, cmd_size_i, cmd_addr_i, cmd_data_i,
        output rsp_ready_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_data_o, rsp_err_o
    );

    modport slave (
        input  cmd_valid_i, cmd_write_i, cmd_size_i, cmd_addr_i, cmd_data_i,
        input  rsp_ready_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_data_o, rsp_err_o
    );
endinterface

// File: rtl/aud_ram_mon_tx.sv
// ---------------------------------------------------------------------------
// aud_ram_mon_tx
// Command sequencer for AUD RAM-monitor mode. Takes one read/write command
// from the host, serialises it onto the AUD pins, turns the bus around,
// polls the target's ready/busy status, collects read data and returns a
// single response word.
// Ports:
//   clk_sys_i, rst_i : system clock, synchronous active-high reset
//   host             : command/response channel (aud_ram_mon_tx_if.slave)
//   aud_ck_o         : AUD clock (idles high)
//   aud_nsync_o      : frame sync, active low
//   aud_data_o/_oe_o : nibble to target and its pad output enable
//   aud_data_i       : nibble from target
//   busy_o           : high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module aud_ram_mon_tx #(
    parameter int unsigned g_clk_div = 2,
    parameter int unsigned g_timeout = 1024
) (
    input  logic             clk_sys_i,
    input  logic             rst_i,
    aud_ram_mon_tx_if.slave  host,
    output logic             aud_ck_o,
    output logic             aud_nsync_o,
    output logic [3:0]       aud_data_o,
    output logic             aud_data_oe_o,
    input  logic [3:0]       aud_data_i,
    output logic             busy_o
);

    localparam int unsigned PH_W   = $clog2(g_clk_div) + 1;
    localparam int unsigned BUSY_W = $clog2(g_timeout + 1);

    // Last cycle of the low phase and last cycle of the whole AUD_CK period.
    localparam logic [PH_W-1:0]   PH_LOW_LAST = PH_W'(g_clk_div - 1);
    localparam logic [PH_W-1:0]   PH_LAST     = PH_W'(2 * g_clk_div - 1);
    localparam logic [BUSY_W-1:0] BUSY_MAX    = BUSY_W'(g_timeout);

    typedef enum logic [2:0] {
        S_IDLE, S_SEND, S_TURN, S_WAIT, S_READ, S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [4:0]        nib_q, nib_d;
    logic [BUSY_W-1:0] busy_cnt_q, busy_cnt_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              ck_q, ck_d;
    logic              nsync_q, nsync_d;
    logic [3:0]        dout_q, dout_d;
    logic              oe_q, oe_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    // Nibbles of payload: byte=2, word=4, long=8.
    function automatic logic [4:0] nib_count(input logic [1:0] size);
        case (size)
            2'b00:   return 5'd2;
            2'b01:   return 5'd4;
            default: return 5'd8;
        endcase
    endfunction

    // Nibble k of the outgoing frame: command, 8 address nibbles, then the
    // low N data nibbles of a write, most significant first.
    function automatic logic [3:0] send_nibble(input logic [4:0]  k,
                                               input logic        wr,
                                               input logic [1:0]  size,
                                               input logic [31:0] addr,
                                               input logic [31:0] data);
        logic [31:0] t;
        int          n;
        n = int'(nib_count(size));
        if (k == 5'd0)
            t = {28'd0, wr, 1'b0, size};
        else if (k <= 5'd8)
            t = addr >> (4 * (8 - int'(k)));
        else
            t = data >> (4 * (n - 1 - (int'(k) - 9)));
        return t[3:0];
    endfunction

    logic       period_end;
    logic [4:0] send_total;
    logic [BUSY_W-1:0] busy_inc;

    assign period_end = (ph_q == PH_LAST);
    assign send_total = 5'd9 + (wr_q ? nib_count(size_q) : 5'd0);
    assign busy_inc   = (busy_cnt_q == BUSY_MAX) ? busy_cnt_q : busy_cnt_q + 1'b1;

    // NOTE: every signal driven here gets its default first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        nib_d       = nib_q;
        busy_cnt_d  = busy_cnt_q;
        wr_d        = wr_q;
        size_d      = size_q;
        addr_d      = addr_q;
        data_d      = data_q;
        ck_d        = ck_q;
        nsync_d     = nsync_q;
        dout_d      = dout_q;
        oe_d        = oe_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;

        // AUD_CK generation for all pin-active states. Outputs only move at
        // the falling edge, i.e. on the cycle after period_end.
        if (state_q inside {S_SEND, S_TURN, S_WAIT, S_READ}) begin
            if (period_end) begin
                ph_d = '0;
                ck_d = 1'b0;
            end else begin
                ph_d = ph_q + 1'b1;
                if (ph_q == PH_LOW_LAST)
                    ck_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (host.cmd_valid_i) begin
                    if (host.cmd_size_i == 2'b11) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                    end else begin
                        state_d    = S_SEND;
                        wr_d       = host.cmd_write_i;
                        size_d     = host.cmd_size_i;
                        addr_d     = host.cmd_addr_i;
                        data_d     = host.cmd_data_i;
                        ph_d       = '0;
                        nib_d      = '0;
                        busy_cnt_d = '0;
                        ck_d       = 1'b0;
                        nsync_d    = 1'b0;
                        oe_d       = 1'b1;
                        dout_d     = {host.cmd_write_i, 1'b0, host.cmd_size_i};
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b0;
                    end
                end
            end

            S_SEND: begin
                if (period_end) begin
                    if (nib_q == send_total - 5'd1) begin
                        state_d = S_TURN;
                        nsync_d = 1'b1;
                        oe_d    = 1'b0;
                        dout_d  = '0;
                    end else begin
                        nib_d  = nib_q + 5'd1;
                        dout_d = send_nibble(nib_q + 5'd1, wr_q, size_q, addr_q, data_q);
                    end
                end
            end

            S_TURN: begin
                if (period_end) begin
                    state_d    = S_WAIT;
                    busy_cnt_d = '0;
                end
            end

            S_WAIT: begin
                if (period_end) begin
                    if (aud_data_i == 4'b0000) begin
                        busy_cnt_d = busy_inc;
                        if (busy_inc == BUSY_MAX) begin
                            state_d     = S_RESP;
                            ck_d        = 1'b1;
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = 1'b1;
                            rsp_data_d  = '0;
                        end
                    end else if (aud_data_i == 4'b0001) begin
                        busy_cnt_d = '0;
                        if (wr_q) begin
                            state_d     = S_RESP;
                            ck_d        = 1'b1;
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = 1'b0;
                        end else begin
                            state_d = S_READ;
                            nib_d   = '0;
                        end
                    end else begin
                        // Anything but busy/ready is a protocol error.
                        state_d     = S_RESP;
                        ck_d        = 1'b1;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                    end
                end
            end

            S_READ: begin
                if (period_end) begin
                    rsp_data_d = {rsp_data_q[27:0], aud_data_i};
                    if (nib_q == nib_count(size_q) - 5'd1) begin
                        state_d     = S_RESP;
                        ck_d        = 1'b1;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                    end else begin
                        nib_d = nib_q + 5'd1;
                    end
                end
            end

            S_RESP: begin
                if (host.rsp_ready_i) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            ph_q        <= '0;
            nib_q       <= '0;
            busy_cnt_q  <= '0;
            ck_q        <= 1'b1;
            nsync_q     <= 1'b1;
            dout_q      <= '0;
            oe_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            nib_q       <= nib_d;
            busy_cnt_q  <= busy_cnt_d;
            ck_q        <= ck_d;
            nsync_q     <= nsync_d;
            dout_q      <= dout_d;
            oe_q        <= oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // NOTE: the latched command is only read after a fresh accept overwrites
    // it, so these datapath registers carry no reset.
    always_ff @(posedge clk_sys_i) begin
        wr_q   <= wr_d;
        size_q <= size_d;
        addr_q <= addr_d;
        data_q <= data_d;
    end

    assign host.cmd_ready_o = (state_q == S_IDLE);
    assign host.rsp_valid_o = rsp_valid_q;
    assign host.rsp_data_o  = rsp_data_q;
    assign host.rsp_err_o   = rsp_err_q;
    assign aud_ck_o         = ck_q;
    assign aud_nsync_o      = nsync_q;
    assign aud_data_o       = dout_q;
    assign aud_data_oe_o    = oe_q;
    assign busy_o           = (state_q != S_IDLE);

endmodule

// File: tb/tb_aud_ram_mon_tx.sv
// ---------------------------------------------------------------------------
// tb_aud_ram_mon_tx
// Directed bench for aud_ram_mon_tx with g_clk_div=2 (4-cycle AUD_CK period)
// and g_timeout=4. Expected pin nibbles and responses are written out by hand.
// ---------------------------------------------------------------------------
module tb_aud_ram_mon_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       aud_ck, aud_nsync, aud_oe, busy;
    logic [3:0] aud_do;
    logic [3:0] aud_di = 4'h0;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] exp_nibs[$];

    always #5 clk = ~clk;

    aud_ram_mon_tx_if bus ();

    aud_ram_mon_tx #(
        .g_clk_div (2),
        .g_timeout (4)
    ) dut (
        .clk_sys_i     (clk),
        .rst_i         (rst),
        .host          (bus.slave),
        .aud_ck_o      (aud_ck),
        .aud_nsync_o   (aud_nsync),
        .aud_data_o    (aud_do),
        .aud_data_oe_o (aud_oe),
        .aud_data_i    (aud_di),
        .busy_o        (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_pins(input string tag);
        check({tag, "_ck"},    aud_ck,    1);
        check({tag, "_nsync"}, aud_nsync, 1);
        check({tag, "_data"},  aud_do,    0);
        check({tag, "_oe"},    aud_oe,    0);
    endtask

    // One AUD_CK period driven by the sequencer: low 2 cycles, high 2 cycles.
    task automatic check_period(input string tag, input logic [3:0] nib,
                                input logic nsync_exp, input logic oe_exp);
        for (int c = 0; c < 4; c++) begin
            check({tag, "_ck"},    aud_ck,    (c >= 2) ? 1 : 0);
            check({tag, "_nsync"}, aud_nsync, nsync_exp);
            check({tag, "_oe"},    aud_oe,    oe_exp);
            check({tag, "_data"},  aud_do,    nib);
            check({tag, "_busy"},  busy,      1);
            tick();
        end
    endtask

    task automatic check_frame(input string tag);
        foreach (exp_nibs[i]) check_period(tag, exp_nibs[i], 1'b0, 1'b1);
    endtask

    // One AUD_CK period with the target driving the bus.
    task automatic target_period(input string tag, input logic [3:0] nib);
        aud_di = nib;
        check({tag, "_no_rsp"}, bus.rsp_valid_o, 0);
        check_period(tag, 4'h0, 1'b1, 1'b0);
    endtask

    task automatic accept(input logic wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] data);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = wr;
        bus.cmd_size_i  = size;
        bus.cmd_addr_i  = addr;
        bus.cmd_data_i  = data;
        check("accept_ready", bus.cmd_ready_o, 1);
        tick();
        bus.cmd_valid_i = 1'b0;
    endtask

    task automatic check_rsp(input string tag, input logic [31:0] data, input logic err);
        check({tag, "_valid"}, bus.rsp_valid_o, 1);
        check({tag, "_data"},  bus.rsp_data_o,  data);
        check({tag, "_err"},   bus.rsp_err_o,   err);
        check({tag, "_cmdrdy"}, bus.cmd_ready_o, 0);
        check_idle_pins(tag);
    endtask

    task automatic consume(input string tag);
        bus.rsp_ready_i = 1'b1;
        tick();
        bus.rsp_ready_i = 1'b0;
        check({tag, "_valid_low"}, bus.rsp_valid_o, 0);
        check({tag, "_cmdrdy"},    bus.cmd_ready_o, 1);
        check({tag, "_busy"},      busy,            0);
    endtask

    initial begin
        bus.cmd_valid_i = 1'b0;
        bus.cmd_write_i = 1'b0;
        bus.cmd_size_i  = 2'b00;
        bus.cmd_addr_i  = '0;
        bus.cmd_data_i  = '0;
        bus.rsp_ready_i = 1'b0;

        // Reset state
        tick();
        tick();
        check_idle_pins("rst");
        check("rst_cmdrdy", bus.cmd_ready_o, 1);
        check("rst_rspv",   bus.rsp_valid_o, 0);
        check("rst_rspd",   bus.rsp_data_o,  0);
        check("rst_rsperr", bus.rsp_err_o,   0);
        check("rst_busy",   busy,            0);
        rst = 1'b0;
        tick();

        // Read byte at 0x0000_1234: busy, busy, ready, then A, 5
        accept(1'b0, 2'b00, 32'h0000_1234, 32'h0);
        exp_nibs = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4};
        check_frame("rdb_send");
        check_period("rdb_turn", 4'h0, 1'b1, 1'b0);
        target_period("rdb_w0", 4'h0);
        target_period("rdb_w1", 4'h0);
        target_period("rdb_w2", 4'h1);
        target_period("rdb_r0", 4'hA);
        target_period("rdb_r1", 4'h5);
        check_rsp("rdb_rsp", 32'h0000_00A5, 1'b0);
        consume("rdb_done");

        // Write long 0xDEADBEEF to 0x8000_0000, target ready at once
        accept(1'b1, 2'b10, 32'h8000_0000, 32'hDEAD_BEEF);
        exp_nibs = '{4'hA, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                     4'hD, 4'hE, 4'hA, 4'hD, 4'hB, 4'hE, 4'hE, 4'hF};
        check_frame("wrl_send");
        check_period("wrl_turn", 4'h0, 1'b1, 1'b0);
        target_period("wrl_w0", 4'h1);
        check_rsp("wrl_rsp", 32'h0, 1'b0);
        consume("wrl_done");

        // Timeout: target stays busy for 4 samples
        accept(1'b0, 2'b00, 32'h0000_00F0, 32'h0);
        exp_nibs = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0};
        check_frame("tmo_send");
        check_period("tmo_turn", 4'h0, 1'b1, 1'b0);
        target_period("tmo_w0", 4'h0);
        target_period("tmo_w1", 4'h0);
        target_period("tmo_w2", 4'h0);
        target_period("tmo_w3", 4'h0);
        check_rsp("tmo_rsp", 32'h0, 1'b1);
        consume("tmo_done");

        // Protocol error: status 0x7, no READ phase follows
        accept(1'b0, 2'b00, 32'h0000_0000, 32'h0);
        exp_nibs = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        check_frame("prt_send");
        check_period("prt_turn", 4'h0, 1'b1, 1'b0);
        target_period("prt_w0", 4'h7);
        check_rsp("prt_rsp", 32'h0, 1'b1);
        aud_di = 4'h0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("prt_hold_ck",    aud_ck,          1);
            check("prt_hold_valid", bus.rsp_valid_o, 1);
        end
        consume("prt_done");

        // Reserved size: immediate error response, no pin activity
        accept(1'b0, 2'b11, 32'h1111_2222, 32'h3333_4444);
        check_rsp("rsv_rsp", 32'h0, 1'b1);
        bus.cmd_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rsv_hold_valid",  bus.rsp_valid_o, 1);
            check("rsv_hold_err",    bus.rsp_err_o,   1);
            check("rsv_hold_data",   bus.rsp_data_o,  0);
            check("rsv_hold_cmdrdy", bus.cmd_ready_o, 0);
            check("rsv_hold_ck",     aud_ck,          1);
            check("rsv_hold_oe",     aud_oe,          0);
        end
        bus.cmd_valid_i = 1'b0;
        consume("rsv_done");

        // Reset mid-SEND at nibble 3, then a clean read word
        accept(1'b0, 2'b00, 32'h0000_1234, 32'h0);
        exp_nibs = '{4'h0, 4'h0, 4'h0};
        check_frame("mrs_send");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_pins("mrs_rst");
        check("mrs_cmdrdy", bus.cmd_ready_o, 1);
        check("mrs_busy",   busy,            0);
        tick();
        tick();
        check("mrs_no_rsp", bus.rsp_valid_o, 0);

        accept(1'b0, 2'b01, 32'h0000_0010, 32'h0);
        exp_nibs = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
        check_frame("rdw_send");
        check_period("rdw_turn", 4'h0, 1'b1, 1'b0);
        target_period("rdw_w0", 4'h1);
        target_period("rdw_r0", 4'h1);
        target_period("rdw_r1", 4'h2);
        target_period("rdw_r2", 4'h3);
        target_period("rdw_r3", 4'h4);
        check_rsp("rdw_rsp", 32'h0000_1234, 1'b0);
        consume("rdw_done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
